// File: rtl/ws2812b_chain_ctrl.sv
// Frame sequencer feeding a NUM_LEDS pixel buffer to a single-pixel WS2812B serialiser.
// Optional continuous refresh: define WS2812B_CHAIN_AUTO_REFRESH_EN.
module ws2812b_chain_ctrl #(
    parameter int NUM_LEDS     = 8,
    parameter int PIXEL_CYCLES = 860,
    parameter int RESET_CYCLES = 8100,
    localparam int ADDR_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [23:0]       i_wr_data,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_pix_send,
    output logic [7:0]        o_pix_red,
    output logic [7:0]        o_pix_green,
    output logic [7:0]        o_pix_blue
);

    localparam int CNT_MAX = (PIXEL_CYCLES > RESET_CYCLES) ? PIXEL_CYCLES : RESET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_W:0]   LED_COUNT = (ADDR_W + 1)'(NUM_LEDS);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]  PIX_LOAD  = CNT_W'(PIXEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT,
        GAP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [CNT_W-1:0]  count;
    logic [23:0]       mem [NUM_LEDS];

    always_ff @(posedge i_clk) begin
        if (i_wr_en && ({1'b0, i_wr_addr} < LED_COUNT)) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef WS2812B_CHAIN_AUTO_REFRESH_EN
    logic unused_start;
    assign unused_start = i_start;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            index        <= '0;
            count        <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_pix_send   <= 1'b0;
            o_pix_red    <= '0;
            o_pix_green  <= '0;
            o_pix_blue   <= '0;
        end else begin
            o_pix_send   <= 1'b0;
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
`ifdef WS2812B_CHAIN_AUTO_REFRESH_EN
                    state  <= FETCH;
                    index  <= '0;
                    o_busy <= 1'b1;
`else
                    if (i_start) begin
                        state  <= FETCH;
                        index  <= '0;
                        o_busy <= 1'b1;
                    end
`endif
                end
                FETCH: begin
                    // The colour registers double as the buffer's registered read port,
                    // so the pixel is visible in SEND and a same-cycle write reads old data.
                    {o_pix_red, o_pix_green, o_pix_blue} <= mem[index];
                    o_pix_send <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    count <= PIX_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    if (count == '0) begin
                        if (index == LAST_IDX) begin
                            state       <= GAP;
                            count       <= GAP_LOAD;
                            o_pix_red   <= '0;
                            o_pix_green <= '0;
                            o_pix_blue  <= '0;
                        end else begin
                            index <= index + ADDR_W'(1);
                            state <= FETCH;
                        end
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (count == '0) begin
                        o_frame_done <= 1'b1;
`ifdef WS2812B_CHAIN_AUTO_REFRESH_EN
                        state <= FETCH;
                        index <= '0;
`else
                        state  <= IDLE;
                        o_busy <= 1'b0;
`endif
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_chain_ctrl.sv
// Directed bench for ws2812b_chain_ctrl with a 6-pixel chain and default timing.
module tb_ws2812b_chain_ctrl;

    localparam int N      = 6;
    localparam int P      = 860;
    localparam int R      = 8100;
    localparam int PERIOD = P + 2;
    localparam int FRAME  = N * PERIOD + R;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic        start;
    logic        busy, frame_done, pix_send;
    logic [7:0]  pix_red, pix_green, pix_blue;

    ws2812b_chain_ctrl #(
        .NUM_LEDS    (N),
        .PIXEL_CYCLES(P),
        .RESET_CYCLES(R)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_start     (start),
        .o_busy      (busy),
        .o_frame_done(frame_done),
        .o_pix_send  (pix_send),
        .o_pix_red   (pix_red),
        .o_pix_green (pix_green),
        .o_pix_blue  (pix_blue)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          send_cyc[$];
    logic [23:0] send_pix[$];
    int          done_cyc[$];

    always @(negedge clk) begin
        if (pix_send === 1'b1) begin
            send_cyc.push_back(cyc);
            send_pix.push_back({pix_red, pix_green, pix_blue});
        end
        if (frame_done === 1'b1) done_cyc.push_back(cyc);
    end

    int checks   = 0;
    int failures = 0;
    logic [23:0] model[N];

    task automatic write_pix(input logic [2:0] a, input logic [23:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic start_frame(output int s);
        @(negedge clk);
        send_cyc.delete();
        send_pix.delete();
        done_cyc.delete();
        start = 1'b1;
        s     = cyc;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_after_start: got %b want 1", busy);
            failures++;
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < FRAME + 100 && done_cyc.size() == 0; i++) @(negedge clk);
        checks++;
        if (done_cyc.size() == 0) begin
            $display("FAIL %s_done_timeout: got no frame_done want one", tag);
            failures++;
        end
    endtask

    task automatic check_frame(input int s, input string tag);
        wait_done(tag);
        checks++;
        if (send_cyc.size() != N) begin
            $display("FAIL %s_send_count: got %0d want %0d", tag, send_cyc.size(), N);
            failures++;
        end
        for (int k = 0; k < N && k < send_cyc.size(); k++) begin
            checks += 2;
            if (send_cyc[k] != s + 2 + k * PERIOD) begin
                $display("FAIL %s_send_time[%0d]: got %0d want %0d", tag, k,
                         send_cyc[k] - s, 2 + k * PERIOD);
                failures++;
            end
            if (send_pix[k] !== model[k]) begin
                $display("FAIL %s_pixel[%0d]: got %06h want %06h", tag, k, send_pix[k], model[k]);
                failures++;
            end
        end
        if (done_cyc.size() > 0) begin
            checks += 3;
            if (done_cyc[0] != s + 1 + FRAME) begin
                $display("FAIL %s_done_time: got %0d want %0d", tag, done_cyc[0] - s, 1 + FRAME);
                failures++;
            end
            if (busy !== 1'b0) begin
                $display("FAIL %s_busy_at_done: got %b want 0", tag, busy);
                failures++;
            end
            if ({pix_red, pix_green, pix_blue} !== 24'h0) begin
                $display("FAIL %s_pix_idle: got %06h want 000000", tag, {pix_red, pix_green, pix_blue});
                failures++;
            end
            @(negedge clk);
            checks++;
            if (frame_done !== 1'b0) begin
                $display("FAIL %s_done_width: got %b want 0", tag, frame_done);
                failures++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, frame_done, pix_send, pix_red, pix_green, pix_blue} !== 27'h0) begin
            $display("FAIL reset_outputs: got %b%b%b %06h want all zero",
                     busy, frame_done, pix_send, {pix_red, pix_green, pix_blue});
            failures++;
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks += 2;
        if (send_cyc.size() != 0) begin
            $display("FAIL idle_no_send: got %0d sends want 0", send_cyc.size());
            failures++;
        end
        if (busy !== 1'b0) begin
            $display("FAIL idle_busy: got %b want 0", busy);
            failures++;
        end
    endtask

    task automatic test_single_frame();
        int s;
        model[0] = 24'h0000FF; model[1] = 24'h00FF00; model[2] = 24'hFF0000;
        model[3] = 24'h123ABC; model[4] = 24'h80017F; model[5] = 24'h5A5A5A;
        for (int i = 0; i < N; i++) write_pix(3'(i), model[i]);
        start_frame(s);
        check_frame(s, "single");
    endtask

    task automatic test_start_ignored();
        int s;
        start_frame(s);
        wait_until(s + 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_frame(s, "busy_start");
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || send_cyc.size() != N) begin
            $display("FAIL busy_start_requeued: got busy=%b sends=%0d want busy=0 sends=%0d",
                     busy, send_cyc.size(), N);
            failures++;
        end
    endtask

    task automatic test_live_write();
        int s;
        start_frame(s);
        wait_until(s + 1800);
        write_pix(3'd5, 24'hABCDEF);
        write_pix(3'd1, 24'h123456);
        write_pix(3'd6, 24'hFFFFFF);
        write_pix(3'd7, 24'hFFFFFF);
        model[5] = 24'hABCDEF;
        check_frame(s, "live_write");
        model[1] = 24'h123456;
    endtask

    task automatic test_reset_abort();
        int s;
        start_frame(s);
        wait_until(s + 2700);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 2;
        if (busy !== 1'b0 || pix_send !== 1'b0) begin
            $display("FAIL abort_outputs: got busy=%b send=%b want 0 0", busy, pix_send);
            failures++;
        end
        if (send_cyc.size() != 4) begin
            $display("FAIL abort_sends_before: got %0d want 4", send_cyc.size());
            failures++;
        end
        repeat (1000) @(negedge clk);
        checks++;
        if (send_cyc.size() != 4 || busy !== 1'b0) begin
            $display("FAIL abort_quiet: got sends=%0d busy=%b want 4 0", send_cyc.size(), busy);
            failures++;
        end
        start_frame(s);
        check_frame(s, "replay");
    endtask

    task automatic test_back_to_back();
        int s;
        start_frame(s);
        wait_done("b2b_first");
        start_frame(s);
        check_frame(s, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_start_ignored();
        test_live_write();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
